ntt_output_reorder: RTL and testbench

- Streaming reorder buffer at the output end of the NTT pipeline.
- Accepts one 1024-point frame in bit-reversed order, 32 coefficients per beat over 32 beats, and emits the same frame in natural order.
- Sits after the last butterfly stage. It is the reader-side counterpart of the stage permutation network: it undoes the index scrambling the forward stages leave behind.
- Ping-pong buffered, so back-to-back frames stream at full rate.

---
 rtl/ntt_pkg.sv | 32 +++
 rtl/ntt_reorder_bank.sv | 40 ++++
 rtl/ntt_output_reorder.sv | 174 +++++++++++++++++
 tb/tb_ntt_output_reorder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT output reorder buffer: default geometry,
// the per-bank occupancy states and the bit-reversal helper used to map
// between bit-reversed and natural coefficient order.
package ntt_pkg;

  localparam int DEFAULT_DATA_WIDTH_PER_INPUT = 32;
  localparam int DEFAULT_INPUT_PER_CYCLE      = 32;
  localparam int LOG2_LANES                   = $clog2(DEFAULT_INPUT_PER_CYCLE);

  // Occupancy of one L x L storage bank. A bank is written only while
  // EMPTY/FILLING and read only while FULL/DRAINING, so the two sides never
  // touch the same bank in the same cycle.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  // Reverse the low 'width' bits of 'value'; bits above 'width' come back 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        result[width-1-i] = value[i];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ntt_reorder_bank.sv
// One L x L coefficient bank of the output reorder buffer.
// Rows are written whole, one input beat per row. The read port selects a
// column and returns L words where lane m comes from row br(m), which is the
// transpose-with-bit-reversal needed to restore natural order.
module ntt_reorder_bank
  import ntt_pkg::*;
#(
  parameter int  DATA_WIDTH_PER_INPUT = DEFAULT_DATA_WIDTH_PER_INPUT,
  parameter int  INPUT_PER_CYCLE      = DEFAULT_INPUT_PER_CYCLE,
  localparam int B                    = $clog2(INPUT_PER_CYCLE)
) (
  input  logic                                                clk,
  input  logic                                                i_wr_en,
  input  logic [B-1:0]                                        i_wr_row,
  input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] i_wr_data,
  input  logic [B-1:0]                                        i_col,
  output logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] o_rd_data
);

  // r_mem[row][lane]: row = input beat number, lane = input lane.
  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] r_mem [INPUT_PER_CYCLE];

  // Row write of one input beat.
  // NOTE: the storage array has no reset; its contents are only ever read
  // after a full frame has been written, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_row] <= i_wr_data;
    end
  end

  // Column read: lane m of the output beat is word (row br(m), lane i_col).
  always_comb begin
    o_rd_data = '0;
    for (int m = 0; m < INPUT_PER_CYCLE; m++) begin
      o_rd_data[m] = r_mem[B'(bitrev(32'(m), B))][i_col];
    end
  end

endmodule

// File: rtl/ntt_output_reorder.sv
// Streaming ping-pong reorder buffer at the output of the NTT pipeline.
// Accepts a 1024-point frame in bit-reversed order (L lanes x L beats) and
// emits it in natural order. Two banks alternate so that one fills while the
// other drains, sustaining one beat per cycle on both sides.
//
// Build option: define NTT_REORDER_SOF_CHECK_EN to add an in_sof input and a
// sticky sof_err output. With it, a mid-frame in_sof restarts the frame in
// the same bank, and a beat arriving without in_sof at frame start is dropped.
module ntt_output_reorder
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH_PER_INPUT = DEFAULT_DATA_WIDTH_PER_INPUT,
  parameter int INPUT_PER_CYCLE      = DEFAULT_INPUT_PER_CYCLE
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] inData,
  input  logic                                                in_valid,
  output logic                                                in_ready,
`ifdef NTT_REORDER_SOF_CHECK_EN
  input  logic                                                in_sof,
  output logic                                                sof_err,
`endif
  output logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] outData,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic                                                out_sof,
  output logic                                                out_eof
);

  localparam int           L        = INPUT_PER_CYCLE;
  localparam int           B        = $clog2(L);
  localparam logic [B-1:0] LAST_IDX = B'(L - 1);

  typedef logic [L-1:0][DATA_WIDTH_PER_INPUT-1:0] beat_t;

  // Registered control state.
  bank_state_e  r_bank_state [2];
  logic         r_wr_bank;
  logic         r_rd_bank;
  logic [B-1:0] r_wr_cnt;
  logic [B-1:0] r_rd_cnt;

  // Combinational control.
  bank_state_e  w_bank_state_nxt [2];
  logic         w_wr_fire;
  logic         w_wr_store;
  logic         w_wr_done;
  logic         w_sof_restart;
  logic         w_sof_drop;
  logic [B-1:0] w_wr_row;
  logic [1:0]   w_bank_wr_en;
  logic         w_out_valid;
  logic         w_rd_fire;
  logic         w_rd_done;
  logic [B-1:0] w_rd_col;
  beat_t        w_bank_rd [2];

  // Two storage banks sharing the write data; only the addressed bank writes.
  for (genvar g = 0; g < 2; g++) begin : g_bank
    ntt_reorder_bank #(
      .DATA_WIDTH_PER_INPUT (DATA_WIDTH_PER_INPUT),
      .INPUT_PER_CYCLE      (INPUT_PER_CYCLE)
    ) u_bank (
      .clk       (clk),
      .i_wr_en   (w_bank_wr_en[g]),
      .i_wr_row  (w_wr_row),
      .i_wr_data (inData),
      .i_col     (w_rd_col),
      .o_rd_data (w_bank_rd[g])
    );
  end

  // Write-side handshake: accept while the write bank has room, work out
  // which row the beat lands in and whether it completes the frame.
  // NOTE: every signal driven here gets a value on every path (defaults
  // first), so no latches are inferred.
  always_comb begin
    in_ready      = !rst && ((r_bank_state[r_wr_bank] == BANK_EMPTY) ||
                             (r_bank_state[r_wr_bank] == BANK_FILLING));
    w_wr_fire     = in_valid && in_ready;
`ifdef NTT_REORDER_SOF_CHECK_EN
    w_sof_restart = w_wr_fire && in_sof && (r_wr_cnt != '0);
    w_sof_drop    = w_wr_fire && !in_sof && (r_wr_cnt == '0);
`else
    w_sof_restart = 1'b0;
    w_sof_drop    = 1'b0;
`endif
    w_wr_store    = w_wr_fire && !w_sof_drop;
    w_wr_row      = w_sof_restart ? '0 : r_wr_cnt;
    w_wr_done     = w_wr_store && (w_wr_row == LAST_IDX);
    w_bank_wr_en  = '0;
    w_bank_wr_en[r_wr_bank] = w_wr_store;
  end

  // Read-side handshake: a bank is readable once full; the column index is
  // the bit-reversed output beat number.
  always_comb begin
    w_out_valid = !rst && ((r_bank_state[r_rd_bank] == BANK_FULL) ||
                           (r_bank_state[r_rd_bank] == BANK_DRAINING));
    w_rd_fire   = w_out_valid && out_ready;
    w_rd_done   = w_rd_fire && (r_rd_cnt == LAST_IDX);
    w_rd_col    = B'(bitrev(32'(r_rd_cnt), B));
  end

  // Bank next-state: the write and read sides address different banks by
  // construction, so both transitions can apply in the same cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_state_nxt[b] = r_bank_state[b];
      if (w_wr_store && (r_wr_bank == 1'(b))) begin
        w_bank_state_nxt[b] = w_wr_done ? BANK_FULL : BANK_FILLING;
      end
      if (w_rd_fire && (r_rd_bank == 1'(b))) begin
        w_bank_state_nxt[b] = w_rd_done ? BANK_EMPTY : BANK_DRAINING;
      end
    end
  end

  // State register: bank states, pointers and beat counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_state[0] <= BANK_EMPTY;
      r_bank_state[1] <= BANK_EMPTY;
      r_wr_bank       <= 1'b0;
      r_rd_bank       <= 1'b0;
      r_wr_cnt        <= '0;
      r_rd_cnt        <= '0;
    end else begin
      r_bank_state[0] <= w_bank_state_nxt[0];
      r_bank_state[1] <= w_bank_state_nxt[1];
      if (w_wr_store) begin
        r_wr_cnt <= w_wr_done ? '0 : w_wr_row + 1'b1;
      end
      if (w_wr_done) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_fire) begin
        r_rd_cnt <= w_rd_done ? '0 : r_rd_cnt + 1'b1;
      end
      if (w_rd_done) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Output drive: data and framing only while a beat is on offer, else 0.
  // Stored words cannot change under a stalled beat since its bank is not
  // writable, so outData holds while out_ready is low.
  always_comb begin
    out_valid = w_out_valid;
    outData   = w_out_valid ? w_bank_rd[r_rd_bank] : '0;
    out_sof   = w_out_valid && (r_rd_cnt == '0);
    out_eof   = w_out_valid && (r_rd_cnt == LAST_IDX);
  end

`ifdef NTT_REORDER_SOF_CHECK_EN
  logic r_sof_err;

  // Sticky framing error: in_sof disagreed with the beat position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sof_err <= 1'b0;
    end else if (w_wr_fire && (in_sof != (r_wr_cnt == '0))) begin
      r_sof_err <= 1'b1;
    end
  end

  assign sof_err = r_sof_err;
`endif

endmodule

// File: tb/tb_ntt_output_reorder.sv
// Self-checking bench for ntt_output_reorder. A scoreboard turns each
// accepted bit-reversed frame into its natural-order beats by plain index
// arithmetic and compares every offered output beat against it.
module tb_ntt_output_reorder;

  localparam int DW = 32;
  localparam int L  = 32;
  localparam int N  = L * L;

  typedef logic [L-1:0][DW-1:0] beat_t;
  typedef struct {
    beat_t data;
    logic  sof;
  } in_beat_t;
  typedef struct {
    string name;
    int    frames;
    int    in_pct;
    int    out_pct;
    int    stall_len;
    bit    direct;
    int    exp_out;
    int    exp_bubbles;
    int    exp_in_low;
    int    exp_acc_at_low;
    int    exp_latency;
  } scen_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t inData = '0;
  logic  in_valid = 1'b0;
  logic  in_ready;
  logic  in_sof = 1'b0;
  logic  sof_err;
  beat_t outData;
  logic  out_valid;
  logic  out_ready = 1'b0;
  logic  out_sof;
  logic  out_eof;

  ntt_output_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .inData    (inData),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef NTT_REORDER_SOF_CHECK_EN
    .in_sof    (in_sof),
    .sof_err   (sof_err),
`endif
    .outData   (outData),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof)
  );

`ifndef NTT_REORDER_SOF_CHECK_EN
  assign sof_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int       checks = 0;
  int       failures = 0;
  in_beat_t in_q[$];
  beat_t    part_q[$];
  beat_t    exp_q[$];
  int       out_beat_idx = 0;
  int       cyc, n_in_acc, n_out, first_out_cyc, last_out_cyc, acc32_cyc;
  int       in_low_cnt, acc_at_first_low, stall_len;
  bit       direct_mode;
  bit       prev_stalled = 1'b0;
  beat_t    prev_beat = '0;
  logic     sof_err_exp = 1'b0;

  function automatic int bitrev10(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) begin
      if (x[i]) r |= (1 << (9 - i));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One comparison per beat; reports the first differing lane.
  task automatic check_beat(input string name, input beat_t act, input beat_t exp);
    int bad;
    bad = 0;
    for (int m = L - 1; m >= 0; m--) begin
      if (act[m] !== exp[m]) bad = m;
    end
    check($sformatf("%s lane %0d", name, bad), 64'(act[bad]), 64'(exp[bad]));
  endtask

  // Queue nbeats input beats of frame f. Pattern frames carry
  // bitrev10(c*L+l) + (f<<16) so natural output is k*L+m + (f<<16).
  task automatic push_frame(input bit pattern, input int f, input int nbeats);
    in_beat_t ib;
    for (int c = 0; c < nbeats; c++) begin
      for (int l = 0; l < L; l++) begin
        ib.data[l] = pattern ? 32'(bitrev10(c * L + l) + (f << 16)) : $urandom;
      end
      ib.sof = (c == 0);
      in_q.push_back(ib);
    end
  endtask

  // Reference model: collect accepted beats; a complete frame is placed into
  // natural order by full 10-bit reversal of each input index.
  task automatic model_accept(input beat_t d, input logic s);
    bit          drop;
    logic [DW-1:0] nat [N];
    beat_t       b;
    drop = 1'b0;
`ifdef NTT_REORDER_SOF_CHECK_EN
    if (s && part_q.size() != 0) begin
      part_q.delete();
      sof_err_exp = 1'b1;
    end else if (!s && part_q.size() == 0) begin
      drop = 1'b1;
      sof_err_exp = 1'b1;
    end
`endif
    if (!drop) begin
      part_q.push_back(d);
      if (part_q.size() == L) begin
        for (int c = 0; c < L; c++)
          for (int l = 0; l < L; l++)
            nat[bitrev10(c * L + l)] = part_q[c][l];
        for (int k = 0; k < L; k++) begin
          for (int m = 0; m < L; m++) b[m] = nat[k * L + m];
          exp_q.push_back(b);
        end
        part_q.delete();
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 ns later.
  task automatic step(input logic v, input beat_t d, input logic s, input logic rdy);
    int    held;
    beat_t nb;
    beat_t zero;
    zero = '0;
    @(negedge clk);
    in_valid  = v;
    inData    = d;
    in_sof    = s;
    out_ready = rdy;
    #1;
    held = (exp_q.size() + L - 1) / L;
    check("in_ready", 64'(in_ready), 64'(held < 2));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
`ifdef NTT_REORDER_SOF_CHECK_EN
    check("sof_err", 64'(sof_err), 64'(sof_err_exp));
`endif
    if (out_valid && exp_q.size() != 0) begin
      check_beat("outData", outData, exp_q[0]);
      check("out_sof", 64'(out_sof), 64'(out_beat_idx == 0));
      check("out_eof", 64'(out_eof), 64'(out_beat_idx == L - 1));
      if (direct_mode) begin
        for (int m = 0; m < L; m++) nb[m] = 32'(out_beat_idx * L + m + ((n_out / L) << 16));
        check_beat("outData natural", outData, nb);
      end
      if (prev_stalled) check_beat("outData held", outData, prev_beat);
    end else begin
      check_beat("outData idle", outData, zero);
      check("out_sof idle", 64'(out_sof), 64'(0));
      check("out_eof idle", 64'(out_eof), 64'(0));
    end
    if (!in_ready && in_q.size() != 0) begin
      in_low_cnt++;
      if (acc_at_first_low < 0) acc_at_first_low = n_in_acc;
    end
    prev_stalled = out_valid && !rdy;
    prev_beat    = outData;
    if (v && in_ready) begin
      n_in_acc++;
      if (n_in_acc == L) acc32_cyc = cyc;
      model_accept(d, s);
      if (in_q.size() != 0) void'(in_q.pop_front());
    end
    if (out_valid && rdy) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      n_out++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      out_beat_idx = (out_beat_idx + 1) % L;
    end
    cyc++;
  endtask

  task automatic init_counters(input bit direct, input int stall);
    cyc = 0; n_in_acc = 0; n_out = 0;
    first_out_cyc = -1; last_out_cyc = -1; acc32_cyc = -1;
    in_low_cnt = 0; acc_at_first_low = -1;
    direct_mode = direct; stall_len = stall;
  endtask

  task automatic drive_cycle(input int in_pct, input int out_pct);
    logic  v, rdy, s;
    beat_t d;
    v   = (in_q.size() != 0) && ($urandom_range(99) < in_pct);
    rdy = (cyc < stall_len) ? 1'b0 : ($urandom_range(99) < out_pct);
    d   = (in_q.size() != 0) ? in_q[0].data : '0;
    s   = (in_q.size() != 0) ? in_q[0].sof : 1'b0;
    step(v, d, s, rdy);
  endtask

  task automatic drain_all(input string name, input int in_pct, input int out_pct);
    while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < 20000)
      drive_cycle(in_pct, out_pct);
    check({name, " completes"}, 64'(in_q.size() + exp_q.size()), 64'(0));
  endtask

  task automatic run_scenario(input scen_t s);
    init_counters(s.direct, s.stall_len);
    for (int f = 0; f < s.frames; f++) push_frame(s.direct, f, L);
    drain_all(s.name, s.in_pct, s.out_pct);
    check({s.name, " output beats"}, 64'(n_out), 64'(s.exp_out));
    if (s.exp_bubbles >= 0)
      check({s.name, " bubbles"}, 64'((last_out_cyc - first_out_cyc + 1) - n_out), 64'(s.exp_bubbles));
    if (s.exp_in_low >= 0)
      check({s.name, " in_ready low cycles"}, 64'(in_low_cnt), 64'(s.exp_in_low));
    if (s.exp_acc_at_low >= 0)
      check({s.name, " beats accepted before in_ready low"}, 64'(acc_at_first_low), 64'(s.exp_acc_at_low));
    if (s.exp_latency >= 0)
      check({s.name, " first output latency"}, 64'(first_out_cyc - acc32_cyc), 64'(s.exp_latency));
  endtask

  task automatic do_reset(input int ncyc);
    beat_t zero;
    zero = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("in_ready during rst", 64'(in_ready), 64'(0));
      check("out_valid during rst", 64'(out_valid), 64'(0));
      check("out_sof during rst", 64'(out_sof), 64'(0));
      check("out_eof during rst", 64'(out_eof), 64'(0));
      check_beat("outData during rst", outData, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    in_q.delete(); part_q.delete(); exp_q.delete();
    out_beat_idx = 0; sof_err_exp = 1'b0; prev_stalled = 1'b0;
    #1;
    check("in_ready after rst", 64'(in_ready), 64'(1));
    check("sof_err after rst", 64'(sof_err), 64'(0));
  endtask

  scen_t table_s [4];

  initial begin
    //            name      frm in%  out% stall dir  outs bub  inlow acc lat
    table_s[0] = '{"single",   1, 100, 100,   0, 1,  32,   0,   0,  -1,  1};
    table_s[1] = '{"b2b",      3, 100, 100,   0, 1,  96,   0,   0,  -1,  1};
    table_s[2] = '{"stall",    3, 100, 100, 100, 1,  96,  -1,  -1,  64, -1};
    table_s[3] = '{"random",  20,  50,  50,   0, 0, 640,  -1,  -1,  -1, -1};

    init_counters(1'b0, 0);
    do_reset(3);

    for (int i = 0; i < 4; i++) run_scenario(table_s[i]);

    // Reset in the middle of a frame: the 17 beats must never come out.
    init_counters(1'b0, 0);
    push_frame(1'b0, 0, L);
    for (int i = 0; i < 17; i++) step(1'b1, in_q[0].data, in_q[0].sof, 1'b1);
    check("beats accepted before mid-frame rst", 64'(n_in_acc), 64'(17));
    do_reset(2);
    run_scenario('{"post-rst", 1, 100, 100, 0, 1, 32, 0, 0, -1, 1});

`ifdef NTT_REORDER_SOF_CHECK_EN
    // in_sof raised at beat 10: frame restarts there and 31 more beats follow.
    init_counters(1'b1, 0);
    push_frame(1'b1, 5, 10);
    push_frame(1'b1, 0, L);
    drain_all("sof restart", 100, 100);
    check("sof restart output beats", 64'(n_out), 64'(32));
    check("sof_err sticky", 64'(sof_err), 64'(1));
    do_reset(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
